// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: widths, PC select encoding and the branch target helper.
package mycpu_pkg;
  localparam int ADDR_W = 16;
  localparam int INS_W  = 16;

  typedef enum logic [1:0] {
    PS_HOLD = 2'b00,
    PS_INC  = 2'b01,
    PS_BRA  = 2'b10,
    PS_JMP  = 2'b11
  } ps_t;

  // Branch offset lives in ins[8:6] (high) and ins[2:0] (low), signed 6 bits.
  function automatic logic [ADDR_W-1:0] bra_target(input logic [ADDR_W-1:0] pc,
                                                   input logic [INS_W-1:0]  ins);
    logic [ADDR_W-1:0] off;
    off = {{(ADDR_W-6){ins[8]}}, ins[8:6], ins[2:0]};
    return pc + off;
  endfunction
endpackage

// File: rtl/pc_ir_if.sv
// Fetch-side bundle between the control unit / instruction memory and pc_ir.
interface pc_ir_if #(parameter int ICNT_W = 16);
  import mycpu_pkg::*;

  logic              il_in;
  ps_t               ps_in;
  logic [ADDR_W-1:0] ra_in;
  logic [INS_W-1:0]  imem_data_in;
  logic [ADDR_W-1:0] imem_addr_out;
  logic [INS_W-1:0]  ins_out;
  logic              ir_valid_out;
  logic [ICNT_W-1:0] icount_out;

  modport master (
    output il_in, ps_in, ra_in, imem_data_in,
    input  imem_addr_out, ins_out, ir_valid_out, icount_out
  );

  modport slave (
    input  il_in, ps_in, ra_in, imem_data_in,
    output imem_addr_out, ins_out, ir_valid_out, icount_out
  );
endinterface

// File: rtl/pc_ir_svamod.sv
// Simulation-only checker bound into pc_ir: X-checks, reset PC and PC update rules.
module pc_ir_svamod
  import mycpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                ICNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  input logic              il,
  input ps_t               ps,
  input logic [ADDR_W-1:0] ra,
  input logic [INS_W-1:0]  imem_data,
  input logic [ADDR_W-1:0] pc,
  input logic [INS_W-1:0]  ir,
  input logic              ir_valid,
  input logic [ICNT_W-1:0] icount
);

  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({il, ps, ra, imem_data, pc, ir, ir_valid, icount}));

  a_reset_pc: assert property (@(posedge clk) !rst_n |-> pc == RESET_PC);

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ps == PS_HOLD |=> pc == $past(pc));

  a_inc: assert property (@(posedge clk) disable iff (!rst_n)
    ps == PS_INC |=> pc == $past(pc) + 16'd1);

  a_bra: assert property (@(posedge clk) disable iff (!rst_n)
    ps == PS_BRA |=> pc == $past(bra_target(pc, ir)));

  a_jmp: assert property (@(posedge clk) disable iff (!rst_n)
    ps == PS_JMP |=> pc == $past(ra));

endmodule

bind pc_ir pc_ir_svamod #(.RESET_PC(RESET_PC), .ICNT_W(ICNT_W)) u_svamod (
  .clk(clk), .rst_n(rst_n), .il(il), .ps(ps), .ra(ra), .imem_data(imem_data),
  .pc(pc), .ir(ir), .ir_valid(ir_valid), .icount(icount)
);

// File: rtl/pc_ir.sv
// Program counter and instruction register with a saturating fetch counter.
module pc_ir
  import mycpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                ICNT_W   = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  pc_ir_if.slave bus
);

  logic              il;
  ps_t               ps;
  logic [ADDR_W-1:0] ra;
  logic [INS_W-1:0]  imem_data;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [INS_W-1:0]  ir;
  logic              ir_valid;
  logic [ICNT_W-1:0] icount;

  assign il        = bus.il_in;
  assign ps        = bus.ps_in;
  assign ra        = bus.ra_in;
  assign imem_data = bus.imem_data_in;

  // Branch offset comes from the IR as it stands this cycle, before any load.
  always_comb begin
    pc_nxt = pc;
    case (ps)
      PS_HOLD: pc_nxt = pc;
      PS_INC:  pc_nxt = pc + 1'b1;
      PS_BRA:  pc_nxt = bra_target(pc, ir);
      PS_JMP:  pc_nxt = ra;
      default: pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
      icount   <= '0;
    end else begin
      pc <= pc_nxt;
      if (il) begin
        ir       <= imem_data;
        ir_valid <= 1'b1;
        if (icount != '1) icount <= icount + 1'b1;
      end
    end
  end

  assign bus.imem_addr_out = pc;
  assign bus.ins_out       = ir;
  assign bus.ir_valid_out  = ir_valid;
  assign bus.icount_out    = icount;

endmodule

// File: tb/tb_pc_ir.sv
// Directed + random bench for pc_ir against an integer-arithmetic fetch model.
module tb_pc_ir;
  import mycpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0040;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pc_ir_if #(.ICNT_W(16)) bus ();

  pc_ir #(.RESET_PC(RST_PC), .ICNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic [15:0] mem [0:65535];
  assign bus.imem_data_in = mem[bus.imem_addr_out];

  int total = 0;
  int bad   = 0;

  int          m_pc, m_cnt;
  logic [15:0] m_ir;
  bit          m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},    {16'h0, bus.imem_addr_out}, m_pc);
    chk({tag, ".ins"},   {16'h0, bus.ins_out},       {16'h0, m_ir});
    chk({tag, ".vld"},   {31'h0, bus.ir_valid_out},  {31'h0, m_vld});
    chk({tag, ".icnt"},  {16'h0, bus.icount_out},    m_cnt);
  endtask

  task automatic model_reset();
    m_pc = int'(RST_PC); m_ir = '0; m_vld = 0; m_cnt = 0;
  endtask

  // Drive one cycle, advance the model from the old PC/IR, then check after the edge.
  task automatic cycle(input bit il, input ps_t ps, input logic [15:0] ra,
                       input bit do_chk, input string tag);
    int off, nxt;
    bus.il_in = il; bus.ps_in = ps; bus.ra_in = ra;
    off = int'(m_ir[8:6]) * 8 + int'(m_ir[2:0]);
    if (off >= 32) off -= 64;
    case (ps)
      PS_HOLD: nxt = m_pc;
      PS_INC:  nxt = m_pc + 1;
      PS_BRA:  nxt = m_pc + off;
      default: nxt = int'(ra);
    endcase
    nxt = ((nxt % 65536) + 65536) % 65536;
    if (il) begin
      m_ir  = mem[m_pc];
      m_vld = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    m_pc = nxt;
    @(posedge clk); #1;
    if (do_chk) chk_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    bus.il_in = 0; bus.ps_in = PS_HOLD; bus.ra_in = '0;
    model_reset();

    #3 rst_n = 0;
    #1 chk_all("reset_async");
    @(posedge clk); #1;
    chk_all("reset_held");
    @(negedge clk); rst_n = 1;
    #1;

    // First load after reset
    mem[RST_PC] = 16'hA5C3;
    cycle(1, PS_HOLD, '0, 1, "first_load");

    // Increment wrap
    cycle(0, PS_JMP, 16'hFFFF, 1, "jmp_ffff");
    cycle(0, PS_INC, '0, 1, "inc_wrap");

    // Jump + load together; IR comes from the old PC (0000)
    mem[16'h0000] = 16'h01C6;
    cycle(1, PS_JMP, 16'h0010, 1, "jmp_il");
    cycle(0, PS_BRA, '0, 1, "bra_minus2");

    mem[16'h000E] = 16'h00C7;
    cycle(1, PS_JMP, 16'hFFF0, 1, "jmp_fff0");
    cycle(0, PS_BRA, '0, 1, "bra_plus31_wrap");

    // Load and branch in the same cycle: offset uses the pre-load IR
    mem[16'h000F] = 16'h0001;
    cycle(1, PS_BRA, '0, 1, "bra_il");

    // Halted CU freezes everything
    cycle(0, PS_HOLD, 16'hBEEF, 1, "halt1");
    cycle(0, PS_HOLD, 16'h1357, 1, "halt2");

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), ps_t'(2'($urandom)), 16'($urandom), 1, "rand");

    // Reset between edges with a jump pending
    bus.il_in = 1; bus.ps_in = PS_JMP; bus.ra_in = 16'h1234;
    #2 rst_n = 0;
    model_reset();
    #1 chk_all("reset_mid");
    bus.il_in = 0; bus.ps_in = PS_HOLD;
    @(posedge clk); #1;
    chk_all("reset_mid_edge");
    @(negedge clk); rst_n = 1;
    #1;
    cycle(0, PS_HOLD, 16'h1234, 1, "post_rel_hold");
    cycle(0, PS_INC, '0, 1, "post_rel_inc");

    // Counter saturation
    for (int i = 0; i < 65534; i++) cycle(1, PS_HOLD, '0, 0, "");
    chk_all("sat_fffe");
    cycle(1, PS_HOLD, '0, 1, "sat_ffff");
    for (int i = 0; i < 3; i++) cycle(1, PS_HOLD, '0, 0, "");
    chk_all("sat_hold");
    cycle(1, PS_INC, '0, 1, "sat_inc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_ir.md
PC_IR -- requirements
Module: pc_ir

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded at reset.
REQ-002 Parameter: ICNT_W, 16, width of the fetch counter.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: il_in  in  1  instruction load strobe from the control unit (cu il_out).
REQ-006 Port: ps_in  in  2  PC select from the control unit (cu ps_out), type ps_t.
REQ-007 Port: ra_in  in  16  register-file A operand, jump target.
REQ-008 Port: imem_data_in  in  16  instruction memory read data, combinational from imem_addr_out.
REQ-009 Port: imem_addr_out  out  16  instruction memory address, equals PC register.
REQ-010 Port: ins_out  out  16  instruction register contents to the control unit (cu ins_in).
REQ-011 Port: ir_valid_out  out  1  IR holds a fetched instruction since reset.
REQ-012 Port: icount_out  out  ICNT_W  saturating count of IR loads since reset.

Function
REQ-013 The PC register SHALL drive imem_addr_out directly with no combinational path from any input.
REQ-014 ps_in == PS_HOLD (2'b00): PC SHALL keep its value.
REQ-015 ps_in == PS_INC (2'b01): PC SHALL become PC+1 at the next edge.
REQ-016 ps_in == PS_BRA (2'b10): PC SHALL become PC + sign-extend of the 6-bit offset {ins_out[8:6], ins_out[2:0]}.
REQ-017 ps_in == PS_JMP (2'b11): PC SHALL become ra_in.
REQ-018 All PC arithmetic SHALL be 16-bit modulo 2^16; overflow and underflow wrap silently.
REQ-019 il_in == 1: IR SHALL capture imem_data_in at the next edge; ins_out changes one cycle after il_in.
REQ-020 il_in == 0: IR SHALL hold.
REQ-021 il_in and any ps_in in the same cycle: both SHALL take effect; IR captures data addressed by the pre-update PC; the PS_BRA offset uses the pre-update IR.
REQ-022 ir_valid_out SHALL set on the first il_in after reset and stay set until reset.
REQ-023 icount_out SHALL increment by 1 per cycle with il_in == 1 and saturate at all-ones.
REQ-024 The block SHALL have no knowledge of opcodes; halt is a CU matter, and a halted CU (ps HOLD, il 0) freezes PC and IR.

Reset
REQ-025 rst_n low SHALL immediately force PC = RESET_PC, IR = 16'h0000, ir_valid_out = 0, icount_out = 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard any pending PC or IR update in that cycle.
REQ-027 After rst_n deasserts, the first edge SHALL act on inputs normally; no extra idle cycle.

Structure
REQ-028 ps_t (PS_HOLD, PS_INC, PS_BRA, PS_JMP) SHALL be defined in mycpu_pkg and shared with cu.
REQ-029 The constants for address width (16) and instruction width (16) SHALL be in mycpu_pkg.
REQ-030 A checker sub-module pc_ir_svamod (non-synthesis) SHALL be bound alongside: X-checks on all ports, a reset-value check on PC, and the PC update rules of REQ-014..REQ-018.

Verification
REQ-031 Reset, then il=1 with imem_data=16'hA5C3 -> ins_out=16'hA5C3 and icount_out=1 one cycle later, ir_valid_out=1.
REQ-032 PC=16'hFFFF, ps=PS_INC -> PC=16'h0000 next cycle.
REQ-033 PC=16'h0010, ins_out[8:6]=3'b111, ins_out[2:0]=3'b110 (offset -2), ps=PS_BRA -> PC=16'h000E; with offset +31 from PC=16'hFFF0 -> PC=16'h000F.
REQ-034 ps=PS_JMP, ra_in=16'h1234, il=1 same cycle -> PC=16'h1234, IR = data at old PC.
REQ-035 Drive il=1 for 2^16+3 cycles -> icount_out stays 16'hFFFF after saturating.
REQ-036 rst_n low between edges with ps=PS_JMP pending -> PC=RESET_PC at once; no jump after release.
